seq_mantissa_div: RTL

SEQ_MANTISSA_DIV -- requirements
Module: seq_mantissa_div

---
 rtl/seq_mantissa_div_pkg.sv | 14 +
 rtl/seq_mantissa_div_step.sv | 24 ++
 rtl/seq_mantissa_div.sv | 91 +++++++++
 3 files changed

// File: rtl/seq_mantissa_div_pkg.sv
// Shared FP32 constants and the state encoding for the sequential mantissa divider.
package seq_mantissa_div_pkg;

  localparam int FP_MANT_W = 24;
  localparam int FP_EXP_W  = 8;
  localparam int FP32_BIAS = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_mantissa_div_step.sv
// One restoring-division iteration: compare, conditional subtract, shift left.
module seq_mantissa_div_step
  import seq_mantissa_div_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W
) (
  input  logic [MANT_W+1:0] rem,
  input  logic [MANT_W-1:0] divisor,
  output logic              q_bit,
  output logic [MANT_W+1:0] rem_next
);

  localparam int R_W = MANT_W + 2;

  logic [R_W-1:0] div_ext;
  logic [R_W-1:0] diff;

  assign div_ext  = {2'b00, divisor};
  assign q_bit    = (rem >= div_ext);
  assign diff     = q_bit ? (rem - div_ext) : rem;
  // diff < divisor < 2^MANT_W here, so dropping the top bit in the shift loses nothing.
  assign rem_next = {diff[R_W-2:0], 1'b0};

endmodule

// File: rtl/seq_mantissa_div.sv
// Sequential restoring mantissa divider: one quotient bit per cycle, valid/ready on both sides.
module seq_mantissa_div
  import seq_mantissa_div_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int Q_W    = MANT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] operand_dividend,
  input  logic [MANT_W-1:0] operand_divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    result,
  output logic              sticky,
  output logic              div_by_zero
);

  localparam int R_W   = MANT_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  div_state_t        state;
  logic [MANT_W-1:0] divisor_q;
  logic [R_W-1:0]    rem_q;
  logic [Q_W-1:0]    quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_bit;
  logic [R_W-1:0]    rem_next;
  logic              div_zero;

  // A zero divisor saturates the quotient to all ones.
  function automatic logic [Q_W-1:0] sat_quotient(input logic [Q_W-1:0] q, input logic dz);
    return dz ? {Q_W{1'b1}} : q;
  endfunction

  seq_mantissa_div_step #(.MANT_W(MANT_W)) u_step (
    .rem      (rem_q),
    .divisor  (divisor_q),
    .q_bit    (q_bit),
    .rem_next (rem_next)
  );

  assign div_zero  = (divisor_q == '0);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      result      <= '0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            divisor_q <= operand_divisor;
            rem_q     <= {2'b00, operand_dividend};
            quot_q    <= '0;
            cnt_q     <= CNT_W'(Q_W - 1);
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          quot_q[cnt_q] <= q_bit;
          rem_q         <= rem_next;
          if (cnt_q == '0) begin
            // Last step: bit 0 comes straight from the step logic, not the register.
            result      <= sat_quotient({quot_q[Q_W-1:1], q_bit}, div_zero);
            sticky      <= !div_zero && (rem_next != '0);
            div_by_zero <= div_zero;
            state       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
